// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// Carries the optional sub strobe when PIPELINED_CLA_ADDER_SUB_EN is defined.
interface pipelined_cla_adder_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
`ifdef PIPELINED_CLA_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             overflow;

    modport master (
        output in_valid,
        output A,
        output B,
        output C_in,
`ifdef PIPELINED_CLA_ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  S,
        input  C_out,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  C_in,
`ifdef PIPELINED_CLA_ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output S,
        output C_out,
        output overflow
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder: one SEG_WIDTH segment resolved per stage, global stall.
// Optional subtract mode under PIPELINED_CLA_ADDER_SUB_EN.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned SEG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus_io
);
    localparam int unsigned NSTAGE = WIDTH / SEG_WIDTH;

    if ((WIDTH % SEG_WIDTH) != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of SEG_WIDTH");
    end

    typedef struct packed {
        logic                 c_msb;
        logic                 c_out;
        logic [SEG_WIDTH-1:0] sum;
    } seg_res_t;

    // Each carry is a flat sum-of-products of generate/propagate terms, not a ripple chain.
    function automatic seg_res_t cla_seg(input logic [SEG_WIDTH-1:0] a,
                                         input logic [SEG_WIDTH-1:0] b,
                                         input logic                 c_in);
        logic [SEG_WIDTH-1:0] g;
        logic [SEG_WIDTH-1:0] p;
        logic [SEG_WIDTH:0]   c;
        logic                 term;
        logic                 prod;
        seg_res_t             res;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = c_in;
        for (int i = 0; i < SEG_WIDTH; i++) begin
            term = g[i];
            prod = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prod & g[j]);
                prod = prod & p[j];
            end
            c[i+1] = term | (prod & c_in);
        end
        res.sum   = p ^ c[SEG_WIDTH-1:0];
        res.c_out = c[SEG_WIDTH];
        res.c_msb = c[SEG_WIDTH-1];
        return res;
    endfunction

    // acc holds resolved sum segments below the stage index and raw A segments above it.
    logic [WIDTH-1:0] acc_q   [NSTAGE];
    logic [WIDTH-1:0] acc_d   [NSTAGE];
    logic [WIDTH-1:0] b_q     [NSTAGE];
    logic [WIDTH-1:0] b_d     [NSTAGE];
    logic             carry_q [NSTAGE];
    logic             carry_d [NSTAGE];
    logic             valid_q [NSTAGE];
    logic             valid_d [NSTAGE];
    logic             ovf_q;
    logic             ovf_d;

    logic [WIDTH-1:0] st_acc [NSTAGE];
    logic [WIDTH-1:0] st_b   [NSTAGE];
    logic             st_c   [NSTAGE];
    logic             st_v   [NSTAGE];

    logic [WIDTH-1:0] b_eff;
    logic             c_eff;
    logic             advance;
    seg_res_t         seg_res;

`ifdef PIPELINED_CLA_ADDER_SUB_EN
    // Inverting B at entry folds sub into the operand that travels down the pipe.
    assign b_eff = bus_io.sub ? ~bus_io.B : bus_io.B;
    assign c_eff = bus_io.sub | bus_io.C_in;
`else
    assign b_eff = bus_io.B;
    assign c_eff = bus_io.C_in;
`endif

    assign advance          = bus_io.out_ready | ~valid_q[NSTAGE-1];
    assign bus_io.in_ready  = advance;
    assign bus_io.out_valid = valid_q[NSTAGE-1];
    assign bus_io.S         = acc_q[NSTAGE-1];
    assign bus_io.C_out     = carry_q[NSTAGE-1];
    assign bus_io.overflow  = ovf_q;

    always_comb begin
        st_acc[0] = bus_io.A;
        st_b[0]   = b_eff;
        st_c[0]   = c_eff;
        st_v[0]   = bus_io.in_valid;
        for (int k = 1; k < NSTAGE; k++) begin
            st_acc[k] = acc_q[k-1];
            st_b[k]   = b_q[k-1];
            st_c[k]   = carry_q[k-1];
            st_v[k]   = valid_q[k-1];
        end
    end

    always_comb begin
        seg_res = '0;
        ovf_d   = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            seg_res = cla_seg(st_acc[k][k*SEG_WIDTH +: SEG_WIDTH],
                              st_b[k][k*SEG_WIDTH +: SEG_WIDTH],
                              st_c[k]);
            acc_d[k]                           = st_acc[k];
            acc_d[k][k*SEG_WIDTH +: SEG_WIDTH] = seg_res.sum;
            b_d[k]                             = st_b[k];
            carry_d[k]                         = seg_res.c_out;
            valid_d[k]                         = st_v[k];
        end
        // seg_res now belongs to the MSB segment.
        ovf_d = seg_res.c_msb ^ seg_res.c_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '{default: '0};
            b_q     <= '{default: '0};
            carry_q <= '{default: 1'b0};
            valid_q <= '{default: 1'b0};
            ovf_q   <= 1'b0;
        end else if (advance) begin
            acc_q   <= acc_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder. Successor to the fixed 32-bit combinational CLA.
- The operand is split into SEG_WIDTH-bit segments. Each pipeline stage resolves one segment with a combinational CLA, and the carry is registered between stages.
- Valid/ready handshakes on both sides, so the block sits directly on the datapath between register file/operand latch and writeback.
- Produces sum, carry-out and signed overflow.

Parameters:
- WIDTH, 32, operand/sum width in bits.
- SEG_WIDTH, 8, bits resolved per pipeline stage.
- Constraint: WIDTH must be a multiple of SEG_WIDTH; a violation is an elaboration error.
- NSTAGE (localparam) = WIDTH/SEG_WIDTH = pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- C_in  input  1  carry-in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- S  output  WIDTH  sum
- C_out  output  1  carry out of MSB
- overflow  output  1  two's-complement overflow

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 immediately clears all stage valid bits and all data/carry registers to 0.
  - Outputs during reset: out_valid=0, S=0, C_out=0, overflow=0.
  - in_ready=1 while out_valid=0.
- Accept: an input transfer occurs on a clk edge with in_valid && in_ready. Output transfer occurs on out_valid && out_ready.
- Stall rule: advance = out_ready || !out_valid; in_ready = advance.
  - When advance=0, every stage register holds (global stall). S, C_out and overflow stay stable while out_valid=1 and out_ready=0.
- Stage k (k=0..NSTAGE-1):
  - Adds segment k of A and B with the carry registered from stage k-1 (stage 0 uses C_in).
  - Segment results for k'<k are carried forward in skew registers.
  - Operand segments for k'>k are carried forward in de-skew registers.
  - All registers advance only when advance=1.
- Latency: a result appears on out_valid exactly NSTAGE cycles after acceptance, absent stalls.
- Throughput: one result per cycle when out_ready is held high.
- Ordering: results emerge strictly in acceptance order. No drop, no duplicate.
- Bubbles: in_valid=0 on an accepted cycle inserts a bubble. That stage's valid bit is 0 and travels with the data. Bubbles are not collapsed.
- Arithmetic:
  - S = (A + B + C_in) mod 2^WIDTH.
  - C_out = bit WIDTH of the full sum.
  - overflow = carry into MSB XOR carry out of MSB, computed in the final stage.
- Simultaneous output transfer and input accept in the same cycle is legal. The pipeline shifts and the new operand enters stage 0.
- Reset mid-operation flushes all in-flight results. Nothing from before reset emerges afterwards.
- WIDTH == SEG_WIDTH degenerates to a single registered stage with latency 1.

Optional Feature:
- Macro: PIPELINED_CLA_ADDER_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with the operands on accept.
  - When sub=1, stage 0 uses ~B and forces carry-in to 1, ignoring C_in, so S = A - B.
  - C_out is the raw adder carry: 1 means no borrow.
  - overflow is signed subtraction overflow.
  - sub travels with its operand through the pipeline.
- Undefined: no sub port; add-only behaviour as above.

Test Plan (WIDTH=32, SEG_WIDTH=8, latency 4):
- A=0x00000001, B=0xFFFFFFFF, C_in=0, out_ready=1 -> 4 cycles later S=0x00000000, C_out=1, overflow=0.
- A=0x7FFFFFFF, B=0x00000001, C_in=0 -> S=0x80000000, C_out=0, overflow=1. Also A=0x80000000, B=0x80000000 -> S=0, C_out=1, overflow=1.
- 200 back-to-back random operands with in_valid=1, out_ready=1 -> one result per cycle from cycle 4, in order, matching a reference model, including C_in=1 cases.
- Fill pipeline, drop out_ready for 3 cycles -> in_ready=0 for those cycles, and S/C_out/overflow stable. On release, all 4 in-flight results plus new inputs emerge with none lost or duplicated.
- Assert rst_n=0 for half a cycle with 3 results in flight -> out_valid drops immediately without a clock edge, and no stale result appears after release.
- With PIPELINED_CLA_ADDER_SUB_EN: A=5, B=7, sub=1 -> S=0xFFFFFFFE, C_out=0, overflow=0. Also A=0x80000000, B=1, sub=1 -> S=0x7FFFFFFF, overflow=1.
